// File: rtl/skew_sampler.sv
// Per-channel skewed bus sampler: returns the value each channel held k edges before the capture edge.
// Optional feature macro: SKEW_SAMPLER_STALE_EN (fill tracking and dout_stale flags).
module skew_sampler #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CHANNELS*WIDTH-1:0]      din,
  input  logic [CHANNELS*$clog2(DEPTH)-1:0] skew,
  input  logic                           sample_req,
  output logic                           sample_ready,
  output logic [CHANNELS*WIDTH-1:0]      dout,
  output logic [CHANNELS-1:0]            dout_stale,
  output logic                           dout_valid,
  input  logic                           dout_ready
);

  localparam int SW = $clog2(DEPTH);
  localparam int BW = CHANNELS * WIDTH;
  localparam int RN = DEPTH - 1;
  localparam logic [SW-1:0] LAST_IDX = SW'(DEPTH - 2);
  localparam logic [SW:0]   RING_LEN = (SW+1)'(DEPTH - 1);

  logic [BW-1:0]       ring_r [RN];
  logic [SW-1:0]       wr_ptr_r;
  logic [BW-1:0]       dout_r;
  logic [CHANNELS-1:0] dout_stale_r;
  logic                dout_valid_r;
  logic [BW-1:0]       cap_data_s;
  logic [CHANNELS-1:0] cap_stale_s;
  logic                accept_s;

  // Ring slot written k edges ago; k = DEPTH-1 lands on the slot about to be overwritten.
  function automatic logic [SW-1:0] hist_idx(input logic [SW-1:0] ptr, input logic [SW-1:0] k);
    logic [SW:0] sum;
    sum = {1'b0, ptr} + RING_LEN - {1'b0, k};
    if (sum >= RING_LEN) begin
      sum = sum - RING_LEN;
    end else begin
      sum = sum;
    end
    return sum[SW-1:0];
  endfunction

`ifdef SKEW_SAMPLER_STALE_EN
  logic [SW-1:0] fill_r;
  localparam logic [SW-1:0] FILL_MAX = SW'(DEPTH - 1);

  // Count edges since reset, saturating once the whole history exists.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_r <= {SW{1'b0}};
    end else if (fill_r != FILL_MAX) begin
      fill_r <= fill_r + 1'b1;
    end else begin
      fill_r <= fill_r;
    end
  end
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [SW-1:0] k_s;
    logic [SW-1:0] idx_s;
    assign k_s   = skew[c*SW +: SW];
    assign idx_s = hist_idx(wr_ptr_r, k_s);
    assign cap_data_s[c*WIDTH +: WIDTH] = (k_s == {SW{1'b0}}) ? din[c*WIDTH +: WIDTH]
                                                               : ring_r[idx_s][c*WIDTH +: WIDTH];
`ifdef SKEW_SAMPLER_STALE_EN
    assign cap_stale_s[c] = (k_s > fill_r);
`else
    assign cap_stale_s[c] = 1'b0;
`endif
  end

  // History ring: free-running write of din every edge, independent of the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {SW{1'b0}};
      for (int i = 0; i < RN; i++) begin
        ring_r[i] <= {BW{1'b0}};
      end
    end else begin
      ring_r[wr_ptr_r] <= din;
      if (wr_ptr_r == LAST_IDX) begin
        wr_ptr_r <= {SW{1'b0}};
      end else begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
    end
  end

  assign sample_ready = !dout_valid_r || dout_ready;
  assign accept_s     = sample_req && sample_ready;

  // Output stage: load on accept, drop valid on consume, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_r       <= {BW{1'b0}};
      dout_stale_r <= {CHANNELS{1'b0}};
      dout_valid_r <= 1'b0;
    end else if (accept_s) begin
      dout_r       <= cap_data_s;
      dout_stale_r <= cap_stale_s;
      dout_valid_r <= 1'b1;
    end else if (dout_ready) begin
      dout_r       <= dout_r;
      dout_stale_r <= dout_stale_r;
      dout_valid_r <= 1'b0;
    end else begin
      dout_r       <= dout_r;
      dout_stale_r <= dout_stale_r;
      dout_valid_r <= dout_valid_r;
    end
  end

  assign dout       = dout_r;
  assign dout_stale = dout_stale_r;
  assign dout_valid = dout_valid_r;

  skew_sampler_chk #(.BW(BW), .CHANNELS(CHANNELS)) u_chk (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_ready (sample_ready),
    .dout         (dout_r),
    .dout_stale   (dout_stale_r),
    .dout_valid   (dout_valid_r),
    .dout_ready   (dout_ready)
  );

endmodule

// Handshake properties of skew_sampler: ready equation and output hold under backpressure.
module skew_sampler_chk #(
  parameter int BW       = 16,
  parameter int CHANNELS = 4
) (
  input logic                clk,
  input logic                rst_n,
  input logic                sample_ready,
  input logic [BW-1:0]       dout,
  input logic [CHANNELS-1:0] dout_stale,
  input logic                dout_valid,
  input logic                dout_ready
);

  a_ready_eq: assert property (@(posedge clk) disable iff (!rst_n)
    sample_ready == (!dout_valid || dout_ready));

  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    ($past(dout_valid) && !$past(dout_ready)) |-> (dout_valid && $stable(dout) && $stable(dout_stale)));

endmodule

// File: tb/tb_skew_sampler.sv
// Directed self-checking bench for skew_sampler (default parameters WIDTH=4, CHANNELS=4, DEPTH=8).
module tb_skew_sampler;

  logic        clk;
  logic        rst_n;
  logic [15:0] din;
  logic [11:0] skew;
  logic        sample_req;
  logic        sample_ready;
  logic [15:0] dout;
  logic [3:0]  dout_stale;
  logic        dout_valid;
  logic        dout_ready;

  int tests_run;
  int tests_failed;

  localparam logic [11:0] SK_ZERO  = 12'h000;
  localparam logic [11:0] SK_STALE = {3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [11:0] SK_MIX   = {3'd7, 3'd2, 3'd1, 3'd0};
  localparam logic [11:0] SK_ALL1  = {3'd1, 3'd1, 3'd1, 3'd1};
  localparam logic [11:0] SK_ALL2  = {3'd2, 3'd2, 3'd2, 3'd2};
  localparam logic [11:0] SK_ALL7  = {3'd7, 3'd7, 3'd7, 3'd7};

`ifdef SKEW_SAMPLER_STALE_EN
  localparam logic [3:0] EXP_STALE_EARLY = 4'b1100;
  localparam logic [3:0] EXP_STALE_RST   = 4'b1111;
`else
  localparam logic [3:0] EXP_STALE_EARLY = 4'b0000;
  localparam logic [3:0] EXP_STALE_RST   = 4'b0000;
`endif

  skew_sampler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .din          (din),
    .skew         (skew),
    .sample_req   (sample_req),
    .sample_ready (sample_ready),
    .dout         (dout),
    .dout_stale   (dout_stale),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one bus value (same nibble on every channel) and request, then step past the edge.
  task automatic drive_edge(input logic [3:0] v, input logic req, input logic [11:0] sk);
    din        = {4{v}};
    sample_req = req;
    skew       = sk;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n      = 1'b0;
    din        = 16'h0000;
    skew       = SK_ZERO;
    sample_req = 1'b0;
    dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_dout",   {16'h0, dout},        32'h0);
    check_eq("rst_stale",  {28'h0, dout_stale},  32'h0);
    check_eq("rst_valid",  {31'h0, dout_valid},  32'h0);
    check_eq("rst_ready",  {31'h0, sample_ready}, 32'h1);
    rst_n = 1'b1;

    // edges 1..2: stale history
    drive_edge(4'h1, 1'b0, SK_ZERO);
    drive_edge(4'h2, 1'b1, SK_STALE);
    check_eq("stale_dout",  {16'h0, dout},       32'h0012);
    check_eq("stale_flags", {28'h0, dout_stale}, {28'h0, EXP_STALE_EARLY});
    check_eq("stale_valid", {31'h0, dout_valid}, 32'h1);

    drive_edge(4'h3, 1'b0, SK_ZERO);
    check_eq("valid_clear", {31'h0, dout_valid}, 32'h0);
    drive_edge(4'h4, 1'b0, SK_ZERO);
    drive_edge(4'h5, 1'b1, SK_ZERO);
    check_eq("skew0_dout",  {16'h0, dout},       32'h5555);
    check_eq("skew0_stale", {28'h0, dout_stale}, 32'h0);

    for (int e = 6; e <= 8; e++) drive_edge(4'(e), 1'b0, SK_ZERO);
    drive_edge(4'h9, 1'b1, SK_MIX);
    check_eq("mix_dout",  {16'h0, dout},       32'h2789);
    check_eq("mix_stale", {28'h0, dout_stale}, 32'h0);

    for (int e = 10; e <= 19; e++) drive_edge(4'(e), 1'b0, SK_ZERO);
    drive_edge(4'h4, 1'b1, SK_ALL7);
    check_eq("wrap_dout",  {16'h0, dout},       32'hDDDD);
    check_eq("wrap_stale", {28'h0, dout_stale}, 32'h0);

    // backpressure: requests blocked, output frozen
    dout_ready = 1'b0;
    #1;
    check_eq("bp_ready0", {31'h0, sample_ready}, 32'h0);
    for (int e = 21; e <= 25; e++) begin
      drive_edge(4'(e), 1'b1, SK_ALL1);
      check_eq("bp_hold_dout",  {16'h0, dout},         32'hDDDD);
      check_eq("bp_hold_valid", {31'h0, dout_valid},   32'h1);
      check_eq("bp_hold_ready", {31'h0, sample_ready}, 32'h0);
    end

    dout_ready = 1'b1;
    #1;
    check_eq("bp_ready1", {31'h0, sample_ready}, 32'h1);
    drive_edge(4'hA, 1'b1, SK_ZERO);
    check_eq("nobubble_dout",  {16'h0, dout},       32'hAAAA);
    check_eq("nobubble_valid", {31'h0, dout_valid}, 32'h1);
    drive_edge(4'hB, 1'b1, SK_ZERO);
    check_eq("thru1_dout", {16'h0, dout}, 32'hBBBB);
    drive_edge(4'hC, 1'b1, SK_ALL2);
    check_eq("thru2_dout", {16'h0, dout}, 32'hAAAA);

    // hold a capture, then async reset mid-hold
    dout_ready = 1'b0;
    drive_edge(4'hD, 1'b1, SK_ZERO);
    check_eq("hold_before_rst", {16'h0, dout}, 32'hAAAA);
    rst_n = 1'b0;
    #2;
    check_eq("arst_valid", {31'h0, dout_valid},  32'h0);
    check_eq("arst_dout",  {16'h0, dout},        32'h0);
    check_eq("arst_stale", {28'h0, dout_stale},  32'h0);
    check_eq("arst_ready", {31'h0, sample_ready}, 32'h1);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    dout_ready = 1'b1;
    drive_edge(4'h7, 1'b1, SK_ALL1);
    check_eq("post_rst_dout",  {16'h0, dout},       32'h0);
    check_eq("post_rst_stale", {28'h0, dout_stale}, {28'h0, EXP_STALE_RST});
    check_eq("post_rst_valid", {31'h0, dout_valid}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/skew_sampler.md
# skew_sampler

Multi-channel bus sampler that returns, per channel, the value a bus held a programmable number of clock edges before the capture edge. It is the synthesizable, parametrised successor of our clocking-block input-skew experiments: skew 0 gives the preponed (#1step-equivalent) value at the capture edge, and skew k gives the value sampled k edges earlier. It sits between a free-running DUT status bus (e.g. `gnt`) and a checker or monitor, with a valid/ready output handshake.

## Interface
- `WIDTH`, 4: bits per channel.
- `CHANNELS`, 4: number of independent channels.
- `DEPTH`, 8: history depth, power of two ≥ 2; maximum skew is `DEPTH-1`.
- `SW`, derived `$clog2(DEPTH)`: skew-select width per channel (localparam).

Ports:
- `clk` in 1: sampling clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `din` in CHANNELS*WIDTH: observed bus; channel c is `din[c*WIDTH +: WIDTH]`.
- `skew` in CHANNELS*SW: per-channel skew in edges; channel c is `skew[c*SW +: SW]`.
- `sample_req` in 1: capture request, qualified by `sample_ready`.
- `sample_ready` out 1: `!dout_valid || dout_ready`.
- `dout` out CHANNELS*WIDTH: captured values.
- `dout_stale` out CHANNELS: per-channel flag set when the requested history did not yet exist.
- `dout_valid` out 1: `dout`/`dout_stale` hold a capture.
- `dout_ready` in 1: consumer accepts the capture.

## Operation
- One clock domain (`clk`); reset is asynchronous and active-low (`rst_n`).
- History ring: `DEPTH-1` entries of CHANNELS*WIDTH, write pointer `wr_ptr` (wraps modulo `DEPTH-1`), written with `din` on every rising edge regardless of handshake.
- Fill counter `fill` (0..DEPTH-1) increments on every edge and saturates at `DEPTH-1`.
- Accept at edge E when `sample_req && sample_ready` at E. For each channel c with skew k:
  - k = 0: `din` value present at E.
  - k ≥ 1: ring entry written at edge E-k (read before this edge's write).
  - Stale when k > `fill` (pre-edge value). Data then reads the reset-zero ring contents and `dout_stale[c]` = 1.
- Output register loads at E and `dout_valid` is set. Both hold unchanged while `dout_valid && !dout_ready`.
- `dout_valid` clears at an edge with `dout_ready` = 1 and no accepted request.
- Simultaneous `dout_ready` + `sample_req` while valid: the new capture replaces the old one and `dout_valid` stays 1 (no bubble).
- `skew` is sampled only at the accept edge; changes at other times have no effect.

## Timing
- Reset values: `dout` = 0, `dout_stale` = 0, `dout_valid` = 0, `sample_ready` = 1, `wr_ptr` = 0, `fill` = 0, ring = 0.
- Reset asserted mid-operation clears all state immediately; a pending capture is lost.
- Latency: request accepted at edge E → `dout` valid in the cycle after E (one register stage).
- Throughput: one capture per cycle when `dout_ready` is held at 1.
- `sample_ready` is combinational from `dout_valid` and `dout_ready` only. There is no combinational path from `din` or `skew` to outputs.
- Wrap-around: after `DEPTH-1` edges the ring overwrites its oldest entry. Skew `DEPTH-1` returns the entry about to be overwritten at E.

## Configuration
- `SKEW_SAMPLER_STALE_EN`
  - Defined: `fill` counter is present and `dout_stale` is driven as described in Operation.
  - Undefined: `fill` is removed and `dout_stale` is tied to 0. Data behaviour is identical (pre-fill reads still return zeros).

## Test plan
All scenarios use the defaults `WIDTH`=4, `CHANNELS`=4, `DEPTH`=8.
- Skew 0, no backpressure: `din` = 0x1,0x2,0x3… per edge, request at edge with `din`=0x5, all skews 0 → `dout`=0x5555 next cycle, `dout_stale`=0.
- Mixed skew: skews {0,1,2,7}, `din` counting from 0x1 at edge 1, request at edge 9 (`din`=0x9) → channels {0x9,0x8,0x7,0x2}, stale=0.
- Stale: request at edge 2 (first edge after reset is edge 1) with skews {0,1,2,3} → data {0x2,0x1,0x0,0x0}, `dout_stale`=4'b1100.
  - Without `SKEW_SAMPLER_STALE_EN`: same data, `dout_stale`=0.
- Backpressure: capture pending with `dout_ready`=0 for 5 cycles while `sample_req`=1 → `sample_ready`=0, `dout` stable. On the `dout_ready` pulse, the next capture loads with no bubble.
- Wrap: run 20 edges, request with skew 7 on all channels at `din`=0x4 → `dout` = value from 7 edges earlier (0xD on every channel).
- Async reset: assert `rst_n`=0 mid-hold → `dout_valid`, `dout`, `dout_stale` all 0 immediately. The first request after release with skew 1 → stale=1, data 0.
